sprite_rom_arbiter: RTL and testbench
=====================================

Name: sprite_rom_arbiter

Overview:
- Shares one synchronous sprite ROM between the four sprite requesters: Pac-Man, red, green and blue ghosts.
- Grants at most one read per cycle, tags each read with its requester, and returns RGB pixel data to that requester ROM_LAT+1 cycles later.
- Sits between the sprite position/fetch logic and the color mapper. Run/drain control lets the frame sequencer quiesce the ROM, e.g. for reload.

Parameters:
- N_REQ, 4, number of requesters; index 0 = Pac-Man, 1 = red, 2 = green, 3 = blue.
- ADDR_W, 12, sprite ROM address width.
- ROM_LAT, 2, ROM read latency in cycles from Rom_rd to valid Rom_data (1..4 legal).

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  asynchronous, active-low reset.
- En  in  1  level; 1 = arbitrate, 0 = stop granting and drain.
- Req  in  N_REQ  per-requester read request, level; held with Addr until granted.
- Addr  in  N_REQ*ADDR_W  flattened addresses; requester i uses bits [i*ADDR_W +: ADDR_W].
- Gnt  out  N_REQ  one-hot grant, combinational, same cycle as Rom_rd.
- Rom_addr  out  ADDR_W  ROM address, combinational.
- Rom_rd  out  1  ROM read strobe, combinational.
- Rom_data  in  24  ROM output {R[23:16], G[15:8], B[7:0]}.
- Rsp_valid  out  N_REQ  one-hot response strobe, registered.
- Rsp_data  out  24  RGB response, registered, shared by all requesters.
- Busy  out  1  1 when state != IDLE or any read is in flight.

Behaviour:
- Reset (Reset_n=0, asynchronous): state IDLE; round-robin pointer 0; tag pipeline cleared.
  - Outputs during reset: Gnt=0, Rom_rd=0, Rom_addr=0, Rsp_valid=0, Rsp_data=0, Busy=0.
  - Reset mid-operation discards all in-flight reads; no Rsp_valid is produced for them.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN when En=1. Granting starts in the first RUN cycle.
  - RUN -> DRAIN when En=0. No grant is issued in any cycle with En=0.
  - DRAIN -> IDLE once the tag pipeline is empty. DRAIN always completes, even if En returns to 1. IDLE then re-evaluates En.
- Arbitration (RUN and En=1 only):
  - Search Req from the pointer upward, modulo N_REQ; the first set bit wins.
  - Gnt[w]=1, Rom_rd=1, Rom_addr=Addr[w].
  - Pointer updates to (w+1) mod N_REQ on the next edge. The pointer is unchanged when nothing is granted.
  - With no Req set: Gnt=0, Rom_rd=0, Rom_addr=0.
- Handshake:
  - The requester samples Gnt at the clock edge.
  - It may drop Req, or present a new Addr with Req held, in the following cycle.
  - Req with Gnt=0 must hold Addr stable.
- Tag pipeline:
  - Depth ROM_LAT. Each entry is {valid, requester index}, shifting every cycle.
  - When the head entry is valid, the next edge loads Rsp_data<=Rom_data and Rsp_valid<=onehot(index). Otherwise Rsp_valid<=0 and Rsp_data holds.
- Latency: a grant at edge t yields Rsp_valid at edge t+ROM_LAT+1.
- Throughput: 1 read/cycle, back to back; responses return in grant order.
- Fairness: with all Req held, grants rotate 0,1,2,3,0,… with no requester starved beyond N_REQ-1 cycles.
- Busy is combinational from state and pipeline valids.

Optional Feature:
- Macro: SPRITE_ARB_PACMAN_PRIO_EN.
  - Defined: requester 0 (Pac-Man) wins whenever Req[0]=1, regardless of pointer. Requesters 1..N_REQ-1 round-robin among themselves on a separate pointer, advanced only on their grants.
  - Undefined: pure round-robin over all N_REQ as above.

Decomposition:
- Package sprite_arb_pkg:
  - state enum (IDLE, RUN, DRAIN).
  - RGB_W=24.
  - requester index constants REQ_PACMAN=0, REQ_RED=1, REQ_GREEN=2, REQ_BLUE=3.
  - tag struct {valid, idx}.
- One sub-module, rr_picker: combinational, parameter N, inputs req and ptr; outputs one-hot gnt and encoded idx. Instantiated twice when the macro is defined.

Test Plan:
- Reset, En=1, Req=4'b1111 held:
  - Gnt sequence is 0001,0010,0100,1000,0001.
  - With ROM_LAT=2, the first Rsp_valid=0001 arrives 3 cycles after the first grant.
  - Rsp_data equals the ROM word at Addr[0].
- Only Req[2]=1 with Addr[2]=12'h0A5 for 3 cycles:
  - Gnt=0100 every cycle, Rom_addr=0x0A5.
  - Three consecutive Rsp_valid=0100 pulses.
- Four grants issued, En dropped:
  - No further Gnt; Busy=1 until the last Rsp_valid, Busy=0 the cycle after.
  - State reaches IDLE; En re-raised during DRAIN has no effect until IDLE.
- Reset_n pulsed low with 2 reads in flight:
  - All outputs are 0 immediately; no Rsp_valid after release.
  - First post-reset grant goes to requester 0.
- SPRITE_ARB_PACMAN_PRIO_EN defined, Req=1111 held:
  - Gnt=0001 every cycle.
  - Drop Req[0]: grants rotate 0010,0100,1000.
- Undefined macro, pointer at 3, Req=0011:
  - Gnt=0001, then 0010 (wrap-around check).

Source files
------------

// File: rtl/sprite_arb_pkg.sv
// Shared types and constants for the sprite ROM arbiter.
package sprite_arb_pkg;

  localparam int RGB_W = 24;
  localparam int IDX_W = 2;

  localparam int REQ_PACMAN = 0;
  localparam int REQ_RED    = 1;
  localparam int REQ_GREEN  = 2;
  localparam int REQ_BLUE   = 3;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } tag_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping modulo N.
module rr_picker #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx
);

  logic found;
  int   j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = W'(j);
      end
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one synchronous sprite ROM among Pac-Man and the three ghosts, with tagged responses.
// Optional SPRITE_ARB_PACMAN_PRIO_EN: Pac-Man has absolute priority, ghosts round-robin among themselves.
module sprite_rom_arbiter
  import sprite_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int ADDR_W  = 12,
  parameter int ROM_LAT = 2
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    En,
  input  logic [N_REQ-1:0]        Req,
  input  logic [N_REQ*ADDR_W-1:0] Addr,
  output logic [N_REQ-1:0]        Gnt,
  output logic [ADDR_W-1:0]       Rom_addr,
  output logic                    Rom_rd,
  input  logic [RGB_W-1:0]        Rom_data,
  output logic [N_REQ-1:0]        Rsp_valid,
  output logic [RGB_W-1:0]        Rsp_data,
  output logic                    Busy
);

  state_t                 state, state_nx;
  tag_t [ROM_LAT-1:0]     tag_pipe;
  logic                   pipe_busy;
  logic                   grant_en;
  logic [N_REQ-1:0]       pick_gnt;
  logic [IDX_W-1:0]       pick_idx;

  assign grant_en = (state == RUN) && En;

`ifdef SPRITE_ARB_PACMAN_PRIO_EN
  localparam int HI_W = (N_REQ > 2) ? $clog2(N_REQ-1) : 1;

  logic [HI_W-1:0]  ptr_hi;
  logic [N_REQ-2:0] hi_gnt;
  logic [HI_W-1:0]  hi_idx;
  logic [N_REQ-1:0] fix_gnt;
  logic [IDX_W-1:0] fix_idx;

  // Pointer pinned at Pac-Man: whenever Req[0] is set this instance picks it.
  rr_picker #(.N(N_REQ), .W(IDX_W)) u_pick_fix (
    .req (Req),
    .ptr (IDX_W'(REQ_PACMAN)),
    .gnt (fix_gnt),
    .idx (fix_idx)
  );

  rr_picker #(.N(N_REQ-1), .W(HI_W)) u_pick_hi (
    .req (Req[N_REQ-1:1]),
    .ptr (ptr_hi),
    .gnt (hi_gnt),
    .idx (hi_idx)
  );

  assign pick_gnt = Req[REQ_PACMAN] ? fix_gnt : {hi_gnt, 1'b0};
  assign pick_idx = Req[REQ_PACMAN] ? fix_idx : IDX_W'(hi_idx) + 1'b1;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)
      ptr_hi <= '0;
    else if (grant_en && !Req[REQ_PACMAN] && |hi_gnt)
      ptr_hi <= (hi_idx == HI_W'(N_REQ-2)) ? '0 : hi_idx + 1'b1;
  end
`else
  logic [IDX_W-1:0] ptr;

  rr_picker #(.N(N_REQ), .W(IDX_W)) u_pick (
    .req (Req),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)
      ptr <= '0;
    else if (grant_en && |pick_gnt)
      ptr <= (pick_idx == IDX_W'(N_REQ-1)) ? '0 : pick_idx + 1'b1;
  end
`endif

  assign Gnt      = grant_en ? pick_gnt : '0;
  assign Rom_rd   = |Gnt;
  assign Rom_addr = Rom_rd ? Addr[pick_idx*ADDR_W +: ADDR_W] : '0;

  always_comb begin
    pipe_busy = 1'b0;
    for (int i = 0; i < ROM_LAT; i++)
      pipe_busy = pipe_busy | tag_pipe[i].valid;
  end

  assign Busy = (state != IDLE) || pipe_busy;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // DRAIN ignores En so the ROM is guaranteed quiet before IDLE re-evaluates it.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (En)         state_nx = RUN;
      RUN:     if (!En)        state_nx = DRAIN;
      DRAIN:   if (!pipe_busy) state_nx = IDLE;
      default:                 state_nx = IDLE;
    endcase
  end

  // Tag rides alongside the ROM access; head entry lines up with valid Rom_data.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      tag_pipe  <= '0;
      Rsp_valid <= '0;
      Rsp_data  <= '0;
    end else begin
      tag_pipe[0].valid <= Rom_rd;
      tag_pipe[0].idx   <= pick_idx;
      for (int i = 1; i < ROM_LAT; i++)
        tag_pipe[i] <= tag_pipe[i-1];
      if (tag_pipe[ROM_LAT-1].valid) begin
        Rsp_valid <= N_REQ'(1) << tag_pipe[ROM_LAT-1].idx;
        Rsp_data  <= Rom_data;
      end else begin
        Rsp_valid <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Self-checking bench for sprite_rom_arbiter: directed table, corner sequences, random vs. queue model.
module tb_sprite_rom_arbiter;

  localparam int N_REQ   = 4;
  localparam int ADDR_W  = 12;
  localparam int ROM_LAT = 2;

  logic                    Clk = 1'b0;
  logic                    Reset_n = 1'b0;
  logic                    En = 1'b0;
  logic [N_REQ-1:0]        Req = '0;
  logic [N_REQ*ADDR_W-1:0] Addr;
  logic [N_REQ-1:0]        Gnt;
  logic [ADDR_W-1:0]       Rom_addr;
  logic                    Rom_rd;
  logic [23:0]             Rom_data;
  logic [N_REQ-1:0]        Rsp_valid;
  logic [23:0]             Rsp_data;
  logic                    Busy;

  logic [ADDR_W-1:0] addr_a [N_REQ];
  logic [ADDR_W-1:0] addr_d [ROM_LAT];

  int errs = 0;
  int checks = 0;

  sprite_rom_arbiter #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .ROM_LAT(ROM_LAT)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .En(En), .Req(Req), .Addr(Addr),
    .Gnt(Gnt), .Rom_addr(Rom_addr), .Rom_rd(Rom_rd), .Rom_data(Rom_data),
    .Rsp_valid(Rsp_valid), .Rsp_data(Rsp_data), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  always_comb begin
    Addr = '0;
    for (int i = 0; i < N_REQ; i++) Addr[i*ADDR_W +: ADDR_W] = addr_a[i];
  end

  function automatic logic [23:0] rom_fn(input logic [11:0] a);
    return {a[7:0] ^ 8'hC3, a[11:4] + 8'd17, ~a[7:0]};
  endfunction

  // Synchronous ROM with ROM_LAT cycles of read latency.
  always @(posedge Clk) begin
    addr_d[0] <= Rom_addr;
    for (int i = 1; i < ROM_LAT; i++) addr_d[i] <= addr_d[i-1];
  end
  assign Rom_data = rom_fn(addr_d[ROM_LAT-1]);

  function automatic int oh2idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic en, input logic [3:0] rq);
    @(posedge Clk);
    #2;
    En  = en;
    Req = rq;
    #2;
  endtask

  task automatic do_reset;
    Reset_n = 1'b0;
    En      = 1'b0;
    Req     = '0;
    #1;
    chk("rst_gnt", Gnt, 0);
    chk("rst_rom_rd", Rom_rd, 0);
    chk("rst_rom_addr", Rom_addr, 0);
    chk("rst_rsp_valid", Rsp_valid, 0);
    chk("rst_rsp_data", Rsp_data, 0);
    chk("rst_busy", Busy, 0);
    @(posedge Clk);
    #2;
    Reset_n = 1'b1;
  endtask

  typedef struct {
    logic       en;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [3:0] rsp;
    logic       busy;
  } vec_t;

  vec_t tbl [15];

  // Reference model: spec-level round robin plus a queue of outstanding reads.
  typedef struct {
    int          idx;
    int          gc;
    logic [23:0] data;
  } fl_t;

  fl_t         q[$];
  int          m_st, m_ptr, m_ptr_hi, cyc, w;
  logic [23:0] m_rsp_data;
  logic [3:0]  last_gnt, exp_gnt, exp_rsp;
  logic [11:0] exp_addr;

  function automatic int pick(input logic [3:0] rq);
`ifdef SPRITE_ARB_PACMAN_PRIO_EN
    if (rq[0]) return 0;
    for (int i = 0; i < 3; i++) if (rq[1 + (m_ptr_hi + i) % 3]) return 1 + (m_ptr_hi + i) % 3;
`else
    for (int i = 0; i < 4; i++) if (rq[(m_ptr + i) % 4]) return (m_ptr + i) % 4;
`endif
    return -1;
  endfunction

  initial begin
    fl_t e;
    addr_a = '{12'h1A0, 12'h2B1, 12'h0A5, 12'h3C3};
    #1;
    do_reset();

`ifndef SPRITE_ARB_PACMAN_PRIO_EN
    //          en    req      gnt      rsp      busy
    tbl[0]  = '{1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b0};
    tbl[1]  = '{1'b1, 4'b1111, 4'b0001, 4'b0000, 1'b1};
    tbl[2]  = '{1'b1, 4'b1111, 4'b0010, 4'b0000, 1'b1};
    tbl[3]  = '{1'b1, 4'b1111, 4'b0100, 4'b0000, 1'b1};
    tbl[4]  = '{1'b1, 4'b1111, 4'b1000, 4'b0001, 1'b1};
    tbl[5]  = '{1'b1, 4'b1111, 4'b0001, 4'b0010, 1'b1};
    tbl[6]  = '{1'b0, 4'b1111, 4'b0000, 4'b0100, 1'b1};
    tbl[7]  = '{1'b1, 4'b1111, 4'b0000, 4'b1000, 1'b1};
    tbl[8]  = '{1'b1, 4'b1111, 4'b0000, 4'b0001, 1'b1};
    tbl[9]  = '{1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b0};
    tbl[10] = '{1'b1, 4'b1111, 4'b0010, 4'b0000, 1'b1};
    tbl[11] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1};
    tbl[12] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1};
    tbl[13] = '{1'b0, 4'b0000, 4'b0000, 4'b0010, 1'b1};
    tbl[14] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    for (int k = 0; k < 15; k++) begin
      step(tbl[k].en, tbl[k].req);
      chk($sformatf("tbl%0d_gnt", k), Gnt, tbl[k].gnt);
      chk($sformatf("tbl%0d_rom_rd", k), Rom_rd, |tbl[k].gnt);
      chk($sformatf("tbl%0d_rom_addr", k), Rom_addr, (tbl[k].gnt != 0) ? addr_a[oh2idx(tbl[k].gnt)] : 12'h0);
      chk($sformatf("tbl%0d_rsp_valid", k), Rsp_valid, tbl[k].rsp);
      chk($sformatf("tbl%0d_busy", k), Busy, tbl[k].busy);
      if (tbl[k].rsp != 0)
        chk($sformatf("tbl%0d_rsp_data", k), Rsp_data, rom_fn(addr_a[oh2idx(tbl[k].rsp)]));
    end

    // Single requester back to back, then pointer wrap from 3 to 0.
    do_reset();
    step(1'b1, 4'b0000);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 4'b0100);
      chk("solo_gnt", Gnt, 4'b0100);
      chk("solo_rom_addr", Rom_addr, 12'h0A5);
    end
    step(1'b1, 4'b0011);
    chk("wrap_gnt0", Gnt, 4'b0001);
    chk("solo_rsp1", Rsp_valid, 4'b0100);
    chk("solo_data1", Rsp_data, rom_fn(12'h0A5));
    step(1'b1, 4'b0011);
    chk("wrap_gnt1", Gnt, 4'b0010);
    chk("solo_rsp2", Rsp_valid, 4'b0100);
    step(1'b1, 4'b0000);
    chk("solo_rsp3", Rsp_valid, 4'b0100);
    step(1'b1, 4'b0000);
    chk("wrap_rsp0", Rsp_valid, 4'b0001);
    chk("wrap_data0", Rsp_data, rom_fn(addr_a[0]));
    step(1'b0, 4'b0000);
    chk("wrap_rsp1", Rsp_valid, 4'b0010);
`else
    step(1'b1, 4'b0000);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 4'b1111);
      chk("prio_gnt", Gnt, 4'b0001);
    end
    step(1'b1, 4'b1110);
    chk("prio_rot1", Gnt, 4'b0010);
    step(1'b1, 4'b1110);
    chk("prio_rot2", Gnt, 4'b0100);
    step(1'b1, 4'b1110);
    chk("prio_rot3", Gnt, 4'b1000);
`endif

    // Reset with two reads in flight.
    do_reset();
    for (int k = 0; k < 4; k++) step(1'b1, 4'b1111);
    @(posedge Clk);
    #2;
    chk("pre_rst_rsp", Rsp_valid, 4'b0001);
    do_reset();
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 4'b0000);
      chk("post_rst_no_rsp", Rsp_valid, 0);
    end
    step(1'b1, 4'b1111);
    chk("post_rst_first_gnt", Gnt, 4'b0001);

    // Random traffic against the model.
    @(posedge Clk);
    #2;
    do_reset();
    m_st = 0; m_ptr = 0; m_ptr_hi = 0; cyc = 0;
    q.delete();
    m_rsp_data = '0;
    last_gnt = '0;
    for (int n = 0; n < 3000; n++) begin
      @(posedge Clk);
      #2;
      En = ($urandom_range(0, 19) != 0);
      for (int i = 0; i < N_REQ; i++) begin
        if (!(Req[i] && !last_gnt[i])) begin
          Req[i]    = ($urandom_range(0, 2) != 0);
          addr_a[i] = 12'($urandom_range(0, 4095));
        end
      end
      #2;
      w        = (m_st == 1 && En) ? pick(Req) : -1;
      exp_gnt  = (w >= 0) ? 4'(1 << w) : 4'b0;
      exp_addr = (w >= 0) ? addr_a[w] : 12'h0;
      exp_rsp  = '0;
      if (q.size() > 0 && q[0].gc + ROM_LAT + 1 == cyc) begin
        exp_rsp    = 4'(1 << q[0].idx);
        m_rsp_data = q[0].data;
        void'(q.pop_front());
      end
      chk("rnd_gnt", Gnt, exp_gnt);
      chk("rnd_rom_rd", Rom_rd, |exp_gnt);
      chk("rnd_rom_addr", Rom_addr, exp_addr);
      chk("rnd_rsp_valid", Rsp_valid, exp_rsp);
      chk("rnd_rsp_data", Rsp_data, m_rsp_data);
      chk("rnd_busy", Busy, (m_st != 0) || (q.size() > 0));
      if (w >= 0) begin
        e.idx = w; e.gc = cyc; e.data = rom_fn(addr_a[w]);
        q.push_back(e);
`ifdef SPRITE_ARB_PACMAN_PRIO_EN
        if (w > 0) m_ptr_hi = w % 3;
`else
        m_ptr = (w + 1) % 4;
`endif
      end
      case (m_st)
        0:       if (En) m_st = 1;
        1:       if (!En) m_st = 2;
        default: if (q.size() == 0) m_st = 0;
      endcase
      last_gnt = exp_gnt;
      cyc++;
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
